// File: rtl/ll_hazard_scoreboard_pkg.sv
// Purpose : shared types and constants for the long-latency hazard scoreboard.
// Latency : n/a (declarations only).
// Backpr. : n/a.
//
// Contents: NUM_SRC (source operands per instruction), REG_IDX_W / reg_idx_t
// (index of the default 32-entry register file), wb_sel_e (write-port owner)
// and rr_next(), the round-robin pointer successor with wrap.
package hazard_pkg;

    localparam int NUM_SRC      = 3;
    localparam int DEF_NUM_REGS = 32;
    localparam int REG_IDX_W    = $clog2(DEF_NUM_REGS);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Encoding is visible on wb_sel_o, so values are pinned explicitly.
    typedef enum logic [1:0] {
        WB_PIPE = 2'd0,
        WB_LL   = 2'd1,
        WB_IDLE = 2'd2
    } wb_sel_e;

    // Slot after idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ll_hazard_scoreboard_rr_arbiter.sv
// Purpose : round-robin arbiter; grants the first request at/after the pointer.
// Latency : grant is combinational from req_i; pointer updates on the next edge.
// Backpr. : a requester keeps req_i high until it sees its grant bit.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset (pointer -> 0)
//   req_i    [N] request vector
//   grant_o  [N] one-hot grant (all zero when no request)
module rr_arbiter
    import hazard_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);

    // A one-entry arbiter still needs a legal (1-bit) pointer register.
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;

    always_comb begin
        int  idx;
        logic found;
        grant_o  = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = 0;
        // Walk the ring starting at the pointer; the first live request wins
        // and the pointer moves just past it so it goes last next round.
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                rr_ptr_d     = PTR_W'(rr_next(idx, N));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/ll_hazard_scoreboard.sv
// Purpose : busy-bit scoreboard for long-latency (div/fdiv/fsqrt) destinations plus
//           round-robin sequencing of the shared register-file write port.
// Latency : hazard/grant/select outputs are combinational; busy bits update next edge.
// Backpr. : LL results own the write port; a colliding pipeline writeback sees
//           no_collision_o=0 and retries (at most NUM_LL consecutive blocked cycles).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   issue_valid_i     instruction in ID requests issue
//   issue_rs_i        [NUM_SRC][IDX_W] source indices, issue_rs_use_i marks live ones
//   issue_rd_i        destination index, issue_rd_we_i = writes rd
//   issue_ll_i        instruction is dispatched to an LL unit
//   ll_done_i         [NUM_LL] unit holds a finished result (level until granted)
//   ll_rd_i           [NUM_LL][IDX_W] destination of each unit's result
//   pipe_wb_valid_i   main pipeline wants the write port this cycle
//   ll_grant_o        [NUM_LL] one-hot grant to an LL unit
//   wb_sel_o          write-port owner (wb_sel_e: pipe / LL / idle)
//   no_dependency_o   0 = RAW or WAW hazard on the issuing instruction
//   no_collision_o    0 = pipeline writeback blocked by an LL grant
//   rd_not_busy_o     destination register has no pending LL write
//
// Build option: SCOREBOARD_CLEAR_BYPASS_EN -- when defined, a register whose busy
// bit is being cleared by this cycle's grant already reads as not-busy (the
// consumer picks the value up from the writeback bus). When undefined the hazard
// holds until the bit has actually cleared, costing one extra stall cycle.
module ll_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_LL   = 2,
    parameter bit FP_TYPE  = 1'b0,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            issue_valid_i,
    input  logic [NUM_SRC-1:0][IDX_W-1:0]   issue_rs_i,
    input  logic [NUM_SRC-1:0]              issue_rs_use_i,
    input  logic [IDX_W-1:0]                issue_rd_i,
    input  logic                            issue_rd_we_i,
    input  logic                            issue_ll_i,
    input  logic [NUM_LL-1:0]               ll_done_i,
    input  logic [NUM_LL-1:0][IDX_W-1:0]    ll_rd_i,
    input  logic                            pipe_wb_valid_i,
    output logic [NUM_LL-1:0]               ll_grant_o,
    output logic [1:0]                      wb_sel_o,
    output logic                            no_dependency_o,
    output logic                            no_collision_o,
    output logic                            rd_not_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_LL-1:0]   arb_grant;
    logic                ll_any;
    logic                raw_hzd;
    logic                waw_hzd;
    logic                no_dep;
    logic                no_col;

    // ------------------------------------------------------------------
    // Write-port arbitration among finished LL units
    // ------------------------------------------------------------------
    rr_arbiter #(
        .N (NUM_LL)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (reset),
        .req_i   (ll_done_i),
        .grant_o (arb_grant)
    );

    // Units are being flushed while reset is high, so nothing is granted.
    assign ll_grant_o = reset ? '0 : arb_grant;
    assign ll_any     = |ll_grant_o;

    // ------------------------------------------------------------------
    // Busy-bit clear from the granted unit's destination
    // ------------------------------------------------------------------
    always_comb begin
        clr_vec = '0;
        for (int u = 0; u < NUM_LL; u++) begin
            if (ll_grant_o[u]) begin
                clr_vec[ll_rd_i[u]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Effective busy view used for hazard detection
    // ------------------------------------------------------------------
    always_comb begin
`ifdef SCOREBOARD_CLEAR_BYPASS_EN
        busy_eff = busy_q & ~clr_vec;
`else
        busy_eff = busy_q;
`endif
        // Integer x0 is hardwired; it can never carry a pending write.
        if (!FP_TYPE) begin
            busy_eff[0] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RAW / WAW hazards on the issuing instruction
    // ------------------------------------------------------------------
    always_comb begin
        raw_hzd = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (issue_rs_use_i[s] && busy_eff[issue_rs_i[s]]) begin
                raw_hzd = 1'b1;
            end
        end
        waw_hzd = issue_rd_we_i && busy_eff[issue_rd_i];
    end

    assign no_dep = ~(raw_hzd | waw_hzd);
    assign no_col = ~(ll_any & pipe_wb_valid_i);

    // ------------------------------------------------------------------
    // Output muxing; reset forces the quiescent values
    // ------------------------------------------------------------------
    always_comb begin
        wb_sel_o        = WB_IDLE;
        no_dependency_o = 1'b1;
        no_collision_o  = 1'b1;
        rd_not_busy_o   = 1'b1;
        if (!reset) begin
            no_dependency_o = no_dep;
            no_collision_o  = no_col;
            rd_not_busy_o   = ~busy_eff[issue_rd_i];
            if (ll_any) begin
                wb_sel_o = WB_LL;
            end else if (pipe_wb_valid_i) begin
                wb_sel_o = WB_PIPE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy-bit next state: set only when the LL instruction really issues
    // ------------------------------------------------------------------
    always_comb begin
        set_vec = '0;
        if (issue_valid_i && no_dep && no_col && issue_ll_i && issue_rd_we_i &&
            !((issue_rd_i == '0) && !FP_TYPE)) begin
            set_vec[issue_rd_i] = 1'b1;
        end
        // Set after clear: a new producer of the same register wins.
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_ll_hazard_scoreboard.sv
module tb_ll_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NL = 2;
    localparam int NR = 32;
`ifdef SCOREBOARD_CLEAR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                issue_valid;
    logic [2:0][4:0]     issue_rs;
    logic [2:0]          issue_rs_use;
    reg_idx_t            issue_rd;
    logic                issue_rd_we;
    logic                issue_ll;
    logic [NL-1:0]       ll_done;
    logic [NL-1:0][4:0]  ll_rd;
    logic                pipe_wb_valid;

    logic [NL-1:0] grant0, grant1;
    logic [1:0]    wbsel0, wbsel1;
    logic          nodep0, nodep1, nocol0, nocol1, rnb0, rnb1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ll_hazard_scoreboard #(.NUM_REGS(NR), .NUM_LL(NL), .FP_TYPE(1'b0)) dut_int (
        .clk(clk), .reset(reset), .issue_valid_i(issue_valid), .issue_rs_i(issue_rs),
        .issue_rs_use_i(issue_rs_use), .issue_rd_i(issue_rd), .issue_rd_we_i(issue_rd_we),
        .issue_ll_i(issue_ll), .ll_done_i(ll_done), .ll_rd_i(ll_rd),
        .pipe_wb_valid_i(pipe_wb_valid), .ll_grant_o(grant0), .wb_sel_o(wbsel0),
        .no_dependency_o(nodep0), .no_collision_o(nocol0), .rd_not_busy_o(rnb0));

    ll_hazard_scoreboard #(.NUM_REGS(NR), .NUM_LL(NL), .FP_TYPE(1'b1)) dut_fp (
        .clk(clk), .reset(reset), .issue_valid_i(issue_valid), .issue_rs_i(issue_rs),
        .issue_rs_use_i(issue_rs_use), .issue_rd_i(issue_rd), .issue_rd_we_i(issue_rd_we),
        .issue_ll_i(issue_ll), .ll_done_i(ll_done), .ll_rd_i(ll_rd),
        .pipe_wb_valid_i(pipe_wb_valid), .ll_grant_o(grant1), .wb_sel_o(wbsel1),
        .no_dependency_o(nodep1), .no_collision_o(nocol1), .rd_not_busy_o(rnb1));

    // ---------------- reference model (index 0: integer RF, 1: FP RF) ----------------
    logic [NR-1:0] m_busy [2];
    int            m_ptr;
    int            e_gidx;
    logic [NL-1:0] e_grant;
    logic [1:0]    e_wbsel;
    logic          e_nocol;
    logic          e_nodep [2];
    logic          e_rnb [2];
    logic [NL-1:0] u_done;
    logic [4:0]    u_rd [NL];

    function automatic bit eff_busy(input int d, input int r);
        bit b;
        b = m_busy[d][r];
        if (d == 0 && r == 0) b = 1'b0;
        if (BYPASS && e_gidx >= 0 && int'(ll_rd[e_gidx]) == r) b = 1'b0;
        return b;
    endfunction

    task automatic model_eval();
        bit hz;
        e_gidx = -1;
        for (int k = 0; k < NL; k++) begin
            int u;
            u = (m_ptr + k) % NL;
            if (e_gidx < 0 && ll_done[u]) e_gidx = u;
        end
        e_grant = '0;
        if (e_gidx >= 0) e_grant[e_gidx] = 1'b1;
        e_nocol = !(e_gidx >= 0 && pipe_wb_valid);
        e_wbsel = (e_gidx >= 0) ? 2'd1 : (pipe_wb_valid ? 2'd0 : 2'd2);
        for (int d = 0; d < 2; d++) begin
            hz = 1'b0;
            for (int s = 0; s < 3; s++)
                if (issue_rs_use[s] && eff_busy(d, int'(issue_rs[s]))) hz = 1'b1;
            if (issue_rd_we && eff_busy(d, int'(issue_rd))) hz = 1'b1;
            e_nodep[d] = !hz;
            e_rnb[d]   = !eff_busy(d, int'(issue_rd));
        end
    endtask

    task automatic model_commit();
        for (int d = 0; d < 2; d++) begin
            if (e_gidx >= 0) m_busy[d][ll_rd[e_gidx]] = 1'b0;
            if (issue_valid && e_nodep[d] && e_nocol && issue_ll && issue_rd_we &&
                !(issue_rd == 0 && d == 0))
                m_busy[d][issue_rd] = 1'b1;
        end
        if (e_gidx >= 0) m_ptr = (e_gidx + 1) % NL;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        issue_valid = 1'b0; issue_rs = '0; issue_rs_use = '0; issue_rd = '0;
        issue_rd_we = 1'b0; issue_ll = 1'b0; ll_done = '0; ll_rd = '0; pipe_wb_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_busy[0] = '0; m_busy[1] = '0; m_ptr = 0; u_done = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        reset = 1'b1;
        ll_done = 2'b11; pipe_wb_valid = 1'b1; issue_rd = 5'd5; issue_rd_we = 1'b1;
        #3;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ((d ? grant1 : grant0) !== 2'b00) begin
                errors++; $display("FAIL reset_grant dut%0d: got %b want 00", d, d ? grant1 : grant0);
            end
            checks++;
            if ((d ? wbsel1 : wbsel0) !== 2'd2) begin
                errors++; $display("FAIL reset_wbsel dut%0d: got %0d want 2", d, d ? wbsel1 : wbsel0);
            end
            checks++;
            if ((d ? nodep1 : nodep0) !== 1'b1 || (d ? nocol1 : nocol0) !== 1'b1) begin
                errors++; $display("FAIL reset_flags dut%0d: nodep=%b nocol=%b want 1 1",
                                   d, d ? nodep1 : nodep0, d ? nocol1 : nocol0);
            end
        end
        tick();
        idle();
        tick();
        reset = 1'b0;
        issue_rd = 5'd5;
        #3;
        checks++;
        if (rnb0 !== 1'b1 || wbsel0 !== 2'd2) begin
            errors++; $display("FAIL post_reset_idle: rnb=%b wbsel=%0d want 1 2", rnb0, wbsel0);
        end
        tick();
    endtask

    task automatic test_raw_waw();
        idle();
        issue_valid = 1'b1; issue_ll = 1'b1; issue_rd = 5'd5; issue_rd_we = 1'b1;
        #3;
        checks++;
        if (nodep0 !== 1'b1) begin
            errors++; $display("FAIL issue_clean: nodep=%b want 1", nodep0);
        end
        tick();
        idle(); issue_rs[0] = 5'd5; issue_rs_use = 3'b001; issue_rd = 5'd9;
        #3;
        checks++;
        if (nodep0 !== 1'b0 || rnb0 !== 1'b1) begin
            errors++; $display("FAIL raw_rs1: nodep=%b rnb=%b want 0 1", nodep0, rnb0);
        end
        tick();
        idle(); issue_rs[2] = 5'd5; issue_rs_use = 3'b100;
        #3;
        checks++;
        if (nodep0 !== 1'b0) begin
            errors++; $display("FAIL raw_rs3: nodep=%b want 0", nodep0);
        end
        tick();
        idle(); issue_rs[1] = 5'd5; issue_rs_use = 3'b000;
        #3;
        checks++;
        if (nodep0 !== 1'b1) begin
            errors++; $display("FAIL unused_src: nodep=%b want 1", nodep0);
        end
        tick();
        idle(); issue_rd = 5'd5; issue_rd_we = 1'b1;
        #3;
        checks++;
        if (nodep0 !== 1'b0 || rnb0 !== 1'b0) begin
            errors++; $display("FAIL waw: nodep=%b rnb=%b want 0 0", nodep0, rnb0);
        end
        tick();
        idle(); issue_rd = 5'd5; issue_rd_we = 1'b0;
        #3;
        checks++;
        if (nodep0 !== 1'b1 || rnb0 !== 1'b0) begin
            errors++; $display("FAIL no_we_rd: nodep=%b rnb=%b want 1 0", nodep0, rnb0);
        end
        tick();
    endtask

    task automatic test_clear();
        idle(); issue_rs[0] = 5'd5; issue_rs_use = 3'b001; ll_done = 2'b01; ll_rd[0] = 5'd5;
        #3;
        checks++;
        if (grant0 !== 2'b01 || wbsel0 !== 2'd1) begin
            errors++; $display("FAIL clear_grant: grant=%b wbsel=%0d want 01 1", grant0, wbsel0);
        end
        checks++;
        if (nodep0 !== BYPASS) begin
            errors++; $display("FAIL clear_grant_cycle_dep: nodep=%b want %b", nodep0, BYPASS);
        end
        tick();
        idle(); issue_rs[0] = 5'd5; issue_rs_use = 3'b001; issue_rd = 5'd5;
        #3;
        checks++;
        if (nodep0 !== 1'b1 || rnb0 !== 1'b1) begin
            errors++; $display("FAIL clear_after: nodep=%b rnb=%b want 1 1", nodep0, rnb0);
        end
        tick();
    endtask

    task automatic test_rr();
        apply_reset();
        ll_done = 2'b11; ll_rd[0] = 5'd3; ll_rd[1] = 5'd4;
        #3;
        checks++;
        if (grant0 !== 2'b01 || wbsel0 !== 2'd1) begin
            errors++; $display("FAIL rr_first: grant=%b wbsel=%0d want 01 1", grant0, wbsel0);
        end
        tick();
        ll_done = 2'b10;
        #3;
        checks++;
        if (grant0 !== 2'b10 || wbsel0 !== 2'd1) begin
            errors++; $display("FAIL rr_second: grant=%b wbsel=%0d want 10 1", grant0, wbsel0);
        end
        tick();
        ll_done = 2'b11;
        #3;
        checks++;
        if (grant0 !== 2'b01) begin
            errors++; $display("FAIL rr_wrap: grant=%b want 01", grant0);
        end
        tick();
        ll_done = 2'b10;
        tick();
        idle();
        tick();
    endtask

    task automatic test_collision();
        idle();
        ll_done = 2'b10; ll_rd[1] = 5'd7; pipe_wb_valid = 1'b1;
        issue_valid = 1'b1; issue_ll = 1'b1; issue_rd = 5'd11; issue_rd_we = 1'b1;
        #3;
        checks++;
        if (nocol0 !== 1'b0 || grant0 !== 2'b10 || wbsel0 !== 2'd1) begin
            errors++; $display("FAIL collide: nocol=%b grant=%b wbsel=%0d want 0 10 1",
                               nocol0, grant0, wbsel0);
        end
        tick();
        idle(); pipe_wb_valid = 1'b1; issue_rd = 5'd11;
        #3;
        checks++;
        if (nocol0 !== 1'b1 || wbsel0 !== 2'd0 || grant0 !== 2'b00) begin
            errors++; $display("FAIL pipe_retry: nocol=%b wbsel=%0d grant=%b want 1 0 00",
                               nocol0, wbsel0, grant0);
        end
        checks++;
        if (rnb0 !== 1'b1) begin
            errors++; $display("FAIL blocked_issue_no_set: rnb=%b want 1", rnb0);
        end
        tick();
        idle();
        #3;
        checks++;
        if (wbsel0 !== 2'd2) begin
            errors++; $display("FAIL idle_wbsel: wbsel=%0d want 2", wbsel0);
        end
        tick();
    endtask

    task automatic test_reg0();
        idle(); issue_valid = 1'b1; issue_ll = 1'b1; issue_rd = 5'd0; issue_rd_we = 1'b1;
        tick();
        idle(); issue_rs[0] = 5'd0; issue_rs_use = 3'b001;
        #3;
        checks++;
        if (nodep0 !== 1'b1 || rnb0 !== 1'b1) begin
            errors++; $display("FAIL int_reg0: nodep=%b rnb=%b want 1 1", nodep0, rnb0);
        end
        checks++;
        if (nodep1 !== 1'b0 || rnb1 !== 1'b0) begin
            errors++; $display("FAIL fp_reg0: nodep=%b rnb=%b want 0 0", nodep1, rnb1);
        end
        tick();
        idle(); ll_done = 2'b01; ll_rd[0] = 5'd0;
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_midop();
        idle(); issue_valid = 1'b1; issue_ll = 1'b1; issue_rd_we = 1'b1; issue_rd = 5'd5;
        tick();
        issue_rd = 5'd8;
        tick();
        idle(); issue_rs[0] = 5'd8; issue_rs_use = 3'b001;
        #3;
        checks++;
        if (nodep0 !== 1'b0) begin
            errors++; $display("FAIL midop_busy: nodep=%b want 0", nodep0);
        end
        tick();
        ll_done = 2'b11; ll_rd[0] = 5'd20; ll_rd[1] = 5'd21; pipe_wb_valid = 1'b1;
        issue_rd = 5'd5; issue_rd_we = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant0 !== 2'b00 || wbsel0 !== 2'd2 || nodep0 !== 1'b1 || nocol0 !== 1'b1 || rnb0 !== 1'b1) begin
            errors++; $display("FAIL midop_reset_outs: grant=%b wbsel=%0d nodep=%b nocol=%b rnb=%b want 00 2 1 1 1",
                               grant0, wbsel0, nodep0, nocol0, rnb0);
        end
        tick();
        reset = 1'b0;
        #3;
        checks++;
        if (grant0 !== 2'b01) begin
            errors++; $display("FAIL midop_ptr_reset: grant=%b want 01", grant0);
        end
        checks++;
        if (nodep0 !== 1'b1) begin
            errors++; $display("FAIL midop_busy_cleared: nodep=%b want 1", nodep0);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random(input int n);
        apply_reset();
        for (int c = 0; c < n; c++) begin
            issue_valid  = 1'($urandom_range(0, 1));
            for (int s = 0; s < 3; s++) issue_rs[s] = 5'($urandom_range(0, 7));
            issue_rs_use = 3'($urandom_range(0, 7));
            issue_rd     = 5'($urandom_range(0, 7));
            issue_rd_we  = 1'($urandom_range(0, 1));
            issue_ll     = ($urandom_range(0, 3) != 0);
            pipe_wb_valid = 1'($urandom_range(0, 1));
            for (int u = 0; u < NL; u++) begin
                if (!u_done[u] && $urandom_range(0, 2) == 0) begin
                    u_done[u] = 1'b1;
                    u_rd[u]   = 5'($urandom_range(0, 7));
                end
                ll_done[u] = u_done[u];
                ll_rd[u]   = u_rd[u];
            end
            #3;
            model_eval();
            checks++;
            if (grant0 !== e_grant || grant1 !== e_grant) begin
                errors++; $display("FAIL rand_grant cyc %0d: got %b/%b want %b", c, grant0, grant1, e_grant);
            end
            checks++;
            if (wbsel0 !== e_wbsel || wbsel1 !== e_wbsel || nocol0 !== e_nocol || nocol1 !== e_nocol) begin
                errors++; $display("FAIL rand_wb cyc %0d: wbsel %0d/%0d nocol %b/%b want %0d %b",
                                   c, wbsel0, wbsel1, nocol0, nocol1, e_wbsel, e_nocol);
            end
            checks++;
            if (nodep0 !== e_nodep[0] || nodep1 !== e_nodep[1]) begin
                errors++; $display("FAIL rand_nodep cyc %0d: got %b/%b want %b/%b",
                                   c, nodep0, nodep1, e_nodep[0], e_nodep[1]);
            end
            checks++;
            if (rnb0 !== e_rnb[0] || rnb1 !== e_rnb[1]) begin
                errors++; $display("FAIL rand_rnb cyc %0d: got %b/%b want %b/%b",
                                   c, rnb0, rnb1, e_rnb[0], e_rnb[1]);
            end
            @(posedge clk);
            model_commit();
            if (e_gidx >= 0) u_done[e_gidx] = 1'b0;
            #1;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw_waw();
        test_clear();
        test_rr();
        test_collision();
        test_reg0();
        test_reset_midop();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
